// File: rtl/fnd_scan_controller.sv
// fnd_scan_controller
//   Time-multiplexed scan sequencer for a 4-digit common-anode FND.
//   Each digit slot is SCAN_DIV cycles: BLANK_CYCLES of dead-time with all
//   digits off, then the digit is driven for the remainder of the slot.
//   Hex nibbles are decoded to active-low 7-seg fonts; leading zeros can be
//   blanked. Inputs are captured into shadow registers at the start of each
//   frame so a frame never shows a mix of old and new values.
//
// Ports
//   i_clk         system clock
//   i_reset       asynchronous, active-high reset
//   i_enable      1 = scan running, 0 = display dark
//   i_digits      four hex nibbles, [3:0] = digit0 (rightmost)
//   i_dp          decimal point per digit, 1 = lit
//   i_lzb         1 = blank leading zeros on digits 3..1
//   o_fnd_com     digit enables, active-low
//   o_fnd_font    segments, active-low; bit0 = a .. bit6 = g, bit7 = dp
//   o_digit_idx   digit currently in its slot
//   o_frame_done  one-cycle pulse at the end of the digit3 drive phase
module fnd_scan_controller #(
  parameter int unsigned SCAN_DIV     = 100_000,
  parameter int unsigned BLANK_CYCLES = 1_000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_enable,
  input  logic [15:0] i_digits,
  input  logic [3:0]  i_dp,
  input  logic        i_lzb,
  output logic [3:0]  o_fnd_com,
  output logic [7:0]  o_fnd_font,
  output logic [1:0]  o_digit_idx,
  output logic        o_frame_done
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BLANK,
    S_DRIVE
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0]      com_q, com_d;
  logic [7:0]      font_q, font_d;
  logic            frame_done_q, frame_done_d;
  logic [15:0]     sh_digits_q, sh_digits_d;
  logic [3:0]      sh_dp_q, sh_dp_d;
  logic            sh_lzb_q, sh_lzb_d;

  logic [3:0]      lz_blank;
  logic [3:0]      nibble;
  logic [7:0]      drive_font;

  function automatic logic [7:0] hex_font(input logic [3:0] n);
    logic [7:0] f;
    case (n)
      4'h0:    f = 8'hC0;
      4'h1:    f = 8'hF9;
      4'h2:    f = 8'hA4;
      4'h3:    f = 8'hB0;
      4'h4:    f = 8'h99;
      4'h5:    f = 8'h92;
      4'h6:    f = 8'h82;
      4'h7:    f = 8'hF8;
      4'h8:    f = 8'h80;
      4'h9:    f = 8'h90;
      4'hA:    f = 8'h88;
      4'hB:    f = 8'h83;
      4'hC:    f = 8'hC6;
      4'hD:    f = 8'hA1;
      4'hE:    f = 8'h86;
      default: f = 8'h8E;
    endcase
    return f;
  endfunction

  // A digit is blanked only if it and every higher digit is zero; the chain
  // runs top-down so a non-zero high digit un-blanks everything below it.
  always_comb begin
    lz_blank    = '0;
    lz_blank[3] = sh_lzb_q & (sh_digits_q[15:12] == 4'h0);
    lz_blank[2] = lz_blank[3] & (sh_digits_q[11:8] == 4'h0);
    lz_blank[1] = lz_blank[2] & (sh_digits_q[7:4] == 4'h0);
  end

  // Decimal point still follows dp on a blanked digit.
  always_comb begin
    nibble        = sh_digits_q[{idx_q, 2'b00} +: 4];
    drive_font    = lz_blank[idx_q] ? 8'hFF : hex_font(nibble);
    drive_font[7] = ~sh_dp_q[idx_q];
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    com_d        = '1;
    font_d       = '1;
    frame_done_d = 1'b0;
    sh_digits_d  = sh_digits_q;
    sh_dp_d      = sh_dp_q;
    sh_lzb_d     = sh_lzb_q;

    if (!i_enable) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d     = S_BLANK;
          cnt_d       = '0;
          idx_d       = '0;
          sh_digits_d = i_digits;
          sh_dp_d     = i_dp;
          sh_lzb_d    = i_lzb;
        end
        S_BLANK: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == BLANK_LAST) begin
            state_d = S_DRIVE;
            com_d   = ~(4'b0001 << idx_q);
            font_d  = drive_font;
          end
        end
        S_DRIVE: begin
          if (cnt_q == SLOT_LAST) begin
            state_d = S_BLANK;
            cnt_d   = '0;
            idx_d   = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              frame_done_d = 1'b1;
              sh_digits_d  = i_digits;
              sh_dp_d      = i_dp;
              sh_lzb_d     = i_lzb;
            end
          end else begin
            cnt_d  = cnt_q + 1'b1;
            com_d  = ~(4'b0001 << idx_q);
            font_d = drive_font;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      com_q        <= '1;
      font_q       <= '1;
      frame_done_q <= 1'b0;
      sh_digits_q  <= '0;
      sh_dp_q      <= '0;
      sh_lzb_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      com_q        <= com_d;
      font_q       <= font_d;
      frame_done_q <= frame_done_d;
      sh_digits_q  <= sh_digits_d;
      sh_dp_q      <= sh_dp_d;
      sh_lzb_q     <= sh_lzb_d;
    end
  end

  assign o_fnd_com    = com_q;
  assign o_fnd_font   = font_q;
  assign o_digit_idx  = idx_q;
  assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// tb_fnd_scan_controller
//   Random plus directed stimulus for fnd_scan_controller, checked every
//   cycle against a reference model that tracks elapsed cycles since enable
//   and derives slot/phase from plain division.
module tb_fnd_scan_controller;

  localparam int unsigned SD    = 10;
  localparam int unsigned BC    = 2;
  localparam int unsigned FRAME = 4 * SD;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] dig;
  logic [3:0]  dp;
  logic        lzb;
  logic [3:0]  com;
  logic [7:0]  font;
  logic [1:0]  idx;
  logic        fd;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  fnd_scan_controller #(
    .SCAN_DIV     (SD),
    .BLANK_CYCLES (BC)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_enable     (en),
    .i_digits     (dig),
    .i_dp         (dp),
    .i_lzb        (lzb),
    .o_fnd_com    (com),
    .o_fnd_font   (font),
    .o_digit_idx  (idx),
    .o_frame_done (fd)
  );

  // reference model state
  bit          m_run = 1'b0;
  int unsigned m_t   = 0;
  logic [15:0] m_dig = '0;
  logic [3:0]  m_dp  = '0;
  logic        m_lzb = 1'b0;
  logic        m_fd  = 1'b0;

  // dead-time monitor state
  int unsigned blank_run  = 0;
  int          last_digit = -1;

  logic [7:0] font_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_font(input int unsigned n);
    logic [15:0] upper;
    logic [7:0]  f;
    upper = m_dig >> (4 * n);
    if (m_lzb && n > 0 && upper == 16'h0) f = 8'hFF;
    else                                  f = font_tbl[upper[3:0]];
    if (m_dp[n]) f[7] = 1'b0;
    return f;
  endfunction

  task automatic capture();
    m_dig = dig;
    m_dp  = dp;
    m_lzb = lzb;
  endtask

  task automatic model_edge();
    m_fd = 1'b0;
    if (rst) begin
      m_run = 1'b0;
      m_dig = '0;
      m_dp  = '0;
      m_lzb = 1'b0;
    end else if (!en) begin
      m_run = 1'b0;
    end else if (!m_run) begin
      m_run = 1'b1;
      m_t   = 0;
      capture();
    end else begin
      m_t++;
      if (m_t % FRAME == 0) begin
        m_fd = 1'b1;
        capture();
      end
    end
  endtask

  task automatic compare();
    logic [3:0]  e_com;
    logic [7:0]  e_font;
    logic [1:0]  e_idx;
    int unsigned slot;
    int unsigned off;
    e_com  = 4'hF;
    e_font = 8'hFF;
    e_idx  = 2'd0;
    if (m_run) begin
      slot  = (m_t % FRAME) / SD;
      off   = m_t % SD;
      e_idx = 2'(slot);
      if (off >= BC) begin
        e_com  = ~(4'b0001 << slot);
        e_font = model_font(slot);
      end
    end
    check("com", com, e_com);
    check("font", font, e_font);
    check("idx", idx, e_idx);
    check("frame_done", fd, m_fd);
    check("com_onehot", ($countones(~com) <= 1), 1);
    if (com == 4'hF) begin
      blank_run++;
    end else begin
      for (int d = 0; d < 4; d++) begin
        if (!com[d]) begin
          if (last_digit >= 0 && last_digit != d) check("dead_time", (blank_run >= BC), 1);
          last_digit = d;
        end
      end
      blank_run = 0;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cyc();
  endtask

  // advance until the model reaches frame position pos (bounded)
  task automatic run_to(input int unsigned pos);
    int unsigned budget;
    budget = 4 * FRAME;
    while (!(m_run && (m_t % FRAME) == pos) && budget > 0) begin
      cyc();
      budget--;
    end
    if (budget == 0) check("run_to_timeout", 0, 1);
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    dig = '0;
    dp  = '0;
    lzb = 1'b0;
    @(negedge clk);
    compare();
    rst = 1'b0;
    run(2);

    // enable with 1234: first lit cycle exactly BC+1 edges after enable
    en  = 1'b1;
    dig = 16'h1234;
    for (int unsigned i = 0; i < BC; i++) begin
      cyc();
      check("enable_blank_com", com, 4'hF);
    end
    cyc();
    check("first_com", com, 4'hE);
    check("first_font", font, 8'h99);
    run(2 * FRAME);

    // leading zero blanking, then all zero
    dig = 16'h0070;
    lzb = 1'b1;
    run(2 * FRAME);
    dig = 16'h0000;
    run(FRAME);

    // dp on a blanked digit, and 8 with dp
    dig = 16'h0008;
    dp  = 4'b0101;
    run(2 * FRAME);
    dp  = '0;
    lzb = 1'b0;

    // change mid-frame during digit2 drive
    dig = 16'h1234;
    run_to(FRAME - 1);
    run_to(2 * SD + BC + 1);
    dig = 16'hABCD;
    run(FRAME + SD);

    // drop enable in the cycle that would produce frame_done
    run_to(FRAME - 1);
    en = 1'b0;
    cyc();
    check("drop_frame_done", fd, 1'b0);
    check("drop_com", com, 4'hF);
    en = 1'b1;
    for (int unsigned i = 0; i < BC; i++) begin
      cyc();
      check("reenable_blank_com", com, 4'hF);
    end
    cyc();
    check("reenable_com", com, 4'hE);

    // asynchronous reset in the middle of a drive phase
    run_to(SD + BC + 3);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_com", com, 4'hF);
    check("async_rst_font", font, 8'hFF);
    check("async_rst_idx", idx, 2'd0);
    check("async_rst_fd", fd, 1'b0);
    m_run = 1'b0;
    m_fd  = 1'b0;
    cyc();
    rst = 1'b0;

    // random phase
    for (int unsigned i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 3))
          0:       dig = 16'($urandom);
          1:       dig = 16'($urandom_range(0, 16'h00FF));
          2:       dig = 16'($urandom_range(0, 15));
          default: dig = 16'h0000;
        endcase
      end
      if ($urandom_range(0, 19) == 0) dp = 4'($urandom);
      if ($urandom_range(0, 29) == 0) lzb = ~lzb;
      if (en) begin
        if ($urandom_range(0, 299) == 0) en = 1'b0;
      end else begin
        if ($urandom_range(0, 4) == 0) en = 1'b1;
      end
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
